// File: rtl/bist_pkg.sv
// bist_pkg: mode encodings, default polynomial and the shared Galois step function.
package bist_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SCAN = 2'b10,
    MODE_MISR = 2'b11
  } mode_e;
  localparam logic [7:0] POLY8 = 8'h71;
  // One Galois shift of a w-bit register (w <= 64) with data folded in; bits above w are masked.
  function automatic logic [63:0] galois_step(input logic [63:0] s, input logic [63:0] poly,
                                              input logic [63:0] din, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return ((s << 1) ^ (s[w-1] ? poly : 64'd0) ^ din) & m;
  endfunction
endpackage

// File: rtl/bilbo_reg_if.sv
// bilbo_reg_if: control, data and status signals of a BILBO register.
interface bilbo_reg_if import bist_pkg::*; #(parameter int WIDTH = 8);
  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] si;
  logic             scan_in;
  logic [WIDTH-1:0] so;
  logic             scan_out;
  logic             done;
  modport master (output en, mode, si, scan_in, input so, scan_out, done);
  modport slave  (input en, mode, si, scan_in, output so, scan_out, done);
endinterface

// File: rtl/bist_step_cnt.sv
// bist_step_cnt: saturating MISR step counter with clear and done flag.
module bist_step_cnt #(
  parameter int NSTEP = 255,
  localparam int CW = $clog2(NSTEP + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic misr_i,
  output logic done_o
);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          done_q, done_d, clr, adv;
  assign cnt_inc = cnt_q + CW'(1);
  assign clr     = en_i && !misr_i;
  assign adv     = en_i && misr_i && !done_q;
  always_comb begin
    cnt_d  = clr ? '0 : adv ? cnt_inc : cnt_q;
    done_d = clr ? 1'b0 : adv ? (cnt_inc == CW'(NSTEP)) : done_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign done_o = done_q;
endmodule

// File: rtl/bilbo_reg.sv
// bilbo_reg: built-in logic block observer (hold / parallel load / scan / MISR compaction).
module bilbo_reg import bist_pkg::*; #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = POLY8,
  parameter int               NSTEP = 255
) (
  input logic        clk,
  input logic        rst,
  bilbo_reg_if.slave bus
);
  logic [WIDTH-1:0] so_q, so_d, misr_nxt;
  logic             done, is_misr;
  assign is_misr  = bus.mode == MODE_MISR;
  assign misr_nxt = WIDTH'(galois_step(64'(so_q), 64'(POLY), 64'(bus.si), WIDTH));
  // Once the signature is complete, further MISR steps leave it frozen.
  always_comb
    so_d = !bus.en                  ? so_q :
           bus.mode == MODE_LOAD    ? bus.si :
           bus.mode == MODE_SCAN    ? {so_q[WIDTH-2:0], bus.scan_in} :
           (is_misr && !done)       ? misr_nxt : so_q;
  always_ff @(posedge clk) begin
    if (rst) so_q <= '0;
    else     so_q <= so_d;
  end
  bist_step_cnt #(.NSTEP(NSTEP)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.en),
    .misr_i (is_misr),
    .done_o (done)
  );
  assign bus.so       = so_q;
  assign bus.scan_out = so_q[WIDTH-1];
  assign bus.done     = done;
endmodule

// File: tb/tb_bilbo_reg.sv
// tb_bilbo_reg: directed vectors with literal checks plus a per-cycle behavioural model compare.
module tb_bilbo_reg;
  import bist_pkg::*;
  localparam int NSTEP = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_so = 0, m_cnt = 0;
  bit   m_done = 1'b0;
  bit   armed = 1'b0;
  bilbo_reg_if #(.WIDTH(8)) bus ();
  bilbo_reg #(.WIDTH(8), .POLY(8'h71), .NSTEP(NSTEP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Signature register viewed as a polynomial over GF(2): multiply by x modulo x^8+x^6+x^5+x^4+1.
  function automatic int mul_x(input int v);
    int t;
    t = v * 2;
    if (t >= 256) t = t ^ 'h171;
    return t;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_so = 0; m_cnt = 0; m_done = 1'b0;
    end else if (bus.en) begin
      if (bus.mode == MODE_MISR) begin
        if (!m_done) begin
          m_so   = mul_x(m_so) ^ int'(bus.si);
          m_cnt  = m_cnt + 1;
          m_done = (m_cnt == NSTEP);
        end
      end else begin
        m_cnt = 0; m_done = 1'b0;
        if (bus.mode == MODE_LOAD) m_so = int'(bus.si);
        if (bus.mode == MODE_SCAN) m_so = ((m_so * 2) + int'(bus.scan_in)) % 256;
      end
    end
    armed = 1'b1;
  end
  always @(negedge clk) begin
    if (armed) begin
      n_cmp = n_cmp + 3;
      if (int'(bus.so) != m_so) begin
        n_err++; $display("FAIL model_so t=%0t got %02h want %02h", $time, bus.so, m_so[7:0]);
      end
      if (bus.scan_out != m_so[7]) begin
        n_err++; $display("FAIL model_scan_out t=%0t got %0b want %0b", $time, bus.scan_out, m_so[7]);
      end
      if (bus.done != m_done) begin
        n_err++; $display("FAIL model_done t=%0t got %0b want %0b", $time, bus.done, m_done);
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input bit en, input mode_e mode, input logic [7:0] si, input bit sin);
    bus.en = en; bus.mode = mode; bus.si = si; bus.scan_in = sin;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic misr_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, MODE_MISR, 8'h00, 1'b0);
  endtask
  logic [7:0] pat;
  initial begin
    bus.en = 1'b0; bus.mode = MODE_HOLD; bus.si = 8'h00; bus.scan_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_so", int'(bus.so), 0);
    chk("rst_scan_out", int'(bus.scan_out), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    cyc(1'b1, MODE_LOAD, 8'h93, 1'b0);
    chk("load_93", int'(bus.so), 'h93);
    chk("load_done", int'(bus.done), 0);
    cyc(1'b1, MODE_LOAD, 8'h80, 1'b0);
    cyc(1'b1, MODE_MISR, 8'h93, 1'b0);
    chk("misr_80_si93", int'(bus.so), 'hE2);
    cyc(1'b1, MODE_LOAD, 8'h80, 1'b0);
    cyc(1'b1, MODE_MISR, 8'h00, 1'b0);
    chk("misr_80_si0", int'(bus.so), 'h71);
    cyc(1'b1, MODE_LOAD, 8'h01, 1'b0);
    misr_n(254);
    chk("done_before_255", int'(bus.done), 0);
    misr_n(1);
    chk("done_at_255", int'(bus.done), 1);
    chk("period_255", int'(bus.so), 'h01);
    cyc(1'b1, MODE_MISR, 8'h5A, 1'b0);
    chk("frozen_so", int'(bus.so), 'h01);
    chk("frozen_done", int'(bus.done), 1);
    cyc(1'b1, MODE_LOAD, 8'hA5, 1'b0);
    chk("load_clears_done", int'(bus.done), 0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("scan_bit%0d", i), int'(bus.scan_out), int'(pat[7-i]));
      cyc(1'b1, MODE_SCAN, 8'h00, 1'b0);
    end
    chk("scan_flush", int'(bus.so), 0);
    cyc(1'b1, MODE_LOAD, 8'h01, 1'b0);
    misr_n(10);
    rst = 1'b1;
    cyc(1'b1, MODE_MISR, 8'h00, 1'b0);
    rst = 1'b0;
    chk("midsig_rst_so", int'(bus.so), 0);
    chk("midsig_rst_done", int'(bus.done), 0);
    cyc(1'b1, MODE_LOAD, 8'h01, 1'b0);
    misr_n(3);
    chk("misr3_so", int'(bus.so), 'h08);
    for (int i = 0; i < 5; i++) cyc(1'b0, MODE_MISR, 8'hFF, 1'b1);
    chk("en0_so", int'(bus.so), 'h08);
    misr_n(251);
    chk("en0_cnt_hold_done0", int'(bus.done), 0);
    misr_n(1);
    chk("en0_cnt_hold_done1", int'(bus.done), 1);
    chk("en0_sig", int'(bus.so), 'h01);
    cyc(1'b1, MODE_HOLD, 8'hFF, 1'b1);
    chk("hold_clr_done", int'(bus.done), 0);
    chk("hold_so", int'(bus.so), 'h01);
    misr_n(254);
    chk("restart_done0", int'(bus.done), 0);
    misr_n(1);
    chk("restart_done1", int'(bus.done), 1);
    cyc(1'b1, MODE_LOAD, 8'h00, 1'b0);
    misr_n(4);
    chk("zero_lockup", int'(bus.so), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
